// File: rtl/mux4x1.sv
// mux4x1: 4:1 lane selector with a registered output and a capture strobe.
// Ports: clk, rst (sync, active-high), en, s, i (4 packed lanes), out, out_valid.
module mux4x1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         s,
  input  logic [4*WIDTH-1:0] i,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] out_d, out_q;
  logic             vld_d, vld_q;

  // Every select code maps to a lane, so no default path is needed.
  always_comb begin
    sel = '0;
    unique case (s)
      2'd0: sel = i[0*WIDTH +: WIDTH];
      2'd1: sel = i[1*WIDTH +: WIDTH];
      2'd2: sel = i[2*WIDTH +: WIDTH];
      2'd3: sel = i[3*WIDTH +: WIDTH];
    endcase
  end

  // out holds while en is low; the strobe only marks capture cycles.
  always_comb begin
    out_d = out_q;
    vld_d = 1'b0;
    if (en) begin
      out_d = sel;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_mux4x1.sv
// tb_mux4x1: table vectors plus scoreboard checks for mux4x1.
// Covers WIDTH=1 and WIDTH=8 instances.
module tb_mux4x1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, en1;
  logic [1:0] s1;
  logic [3:0] i1;
  logic [0:0] out1;
  logic       v1;

  logic        rst8, en8;
  logic [1:0]  s8;
  logic [31:0] i8;
  logic [7:0]  out8;
  logic        v8;

  mux4x1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .s(s1), .i(i1),
    .out(out1), .out_valid(v1)
  );

  mux4x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .s(s8), .i(i8),
    .out(out8), .out_valid(v8)
  );

  typedef struct {
    logic       r;
    logic       e;
    logic [1:0] s;
    logic [3:0] i;
    logic       eo;
    logic       ev;
  } vec_t;

  typedef struct {
    logic [7:0] o;
    logic       v;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m8_out = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(ref exp_t q[$], input string nm,
                         input logic [7:0] ao, input logic av);
    exp_t x;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty got %0h want entry", nm, ao);
    end else begin
      x = q.pop_front();
      chk({nm, ".out"}, {24'd0, ao}, {24'd0, x.o});
      chk({nm, ".valid"}, {31'd0, av}, {31'd0, x.v});
    end
  endtask

  task automatic step1(input vec_t v, input string nm);
    exp_t x;
    rst1 = v.r; en1 = v.e; s1 = v.s; i1 = v.i;
    x.o = {7'd0, v.eo};
    x.v = v.ev;
    q1.push_back(x);
    @(posedge clk);
    #1;
    pop_chk(q1, nm, {7'd0, out1}, v1);
  endtask

  task automatic step8(input logic r, input logic e, input logic [1:0] s,
                       input logic [31:0] i, input string nm);
    exp_t x;
    rst8 = r; en8 = e; s8 = s; i8 = i;
    if (r) begin
      m8_out = '0;
      x.v = 1'b0;
    end else if (e) begin
      m8_out = i[s*8 +: 8];
      x.v = 1'b1;
    end else begin
      x.v = 1'b0;
    end
    x.o = m8_out;
    q8.push_back(x);
    @(posedge clk);
    #1;
    pop_chk(q8, nm, out8, v8);
  endtask

  vec_t tbl[$];

  initial begin
    rst1 = 1'b1; en1 = 1'b0; s1 = '0; i1 = '0;
    rst8 = 1'b1; en8 = 1'b0; s8 = '0; i8 = '0;

    //         r     e     s     i        eo    ev
    tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1010, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1010, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1010, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4'b1010, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b1010, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 4'b1010, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 4'b1010, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 4'b1010, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 2'd3, 4'b1010, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 4'b1010, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 2'd1, 4'b1111, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b1111, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 4'b1011, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd3, 4'b0111, 1'b0, 1'b1});

    for (int k = 0; k < tbl.size(); k++)
      step1(tbl[k], $sformatf("w1_vec%0d", k));

    // Capture a 1, then wiggle s/i between edges with en low.
    step1('{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1}, "w1_pre");
    en1 = 1'b0;
    @(posedge clk);
    #1;
    chk("w1_holdv", {31'd0, v1}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      #2;
      s1 = 2'(k);
      i1 = 4'(k * 5);
      #1;
      chk($sformatf("w1_mid%0d", k), {31'd0, out1}, 32'd1);
      if (k % 3 == 2) begin
        @(posedge clk);
        #1;
      end
    end
    chk("w1_midv", {31'd0, v1}, 32'd0);

    // Wide lanes.
    step8(1'b1, 1'b1, 2'd0, 32'hDDCCBBAA, "w8_rst");
    step8(1'b0, 1'b1, 2'd2, 32'hDDCCBBAA, "w8_s2");
    chk("w8_cc", {24'd0, out8}, 32'h0000_00CC);
    step8(1'b0, 1'b1, 2'd0, 32'hDDCCBBAA, "w8_s0");
    step8(1'b0, 1'b1, 2'd3, 32'hDDCCBBAA, "w8_s3");
    step8(1'b0, 1'b0, 2'd1, 32'h00000000, "w8_hold");
    for (int k = 0; k < 40; k++)
      step8(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), $urandom, $sformatf("w8_rnd%0d", k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
